l2norm_host_driver: RTL

Host-side initiator for the 192-word / 6-batch L2-norm accelerator. It buffers one 192-word input vector written over a simple register-write port, streams the words to the accelerator's `input_valid`/`input_ready` port, and collects the six batch results. For each result it uses the accelerator's `output_valid`/`output_ready` handshake and its `dp_read_addr`/`res` read port. It sits between the MMIO register file and the accelerator instance, sharing the accelerator's clock and reset.

---
 rtl/l2norm_host_driver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/l2norm_host_driver.sv
// Host-side initiator for the 192-word / 6-batch L2-norm accelerator: buffers one
// input vector, streams it over a valid/ready port, then collects the six batch results.
module l2norm_host_driver #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [7:0]         wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               start,
  input  logic [2:0]         rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  output logic               busy,
  output logic               done,
  output logic [31:0]        cycle_count,
  output logic               acc_input_valid,
  output logic [WIDTH-1:0]   acc_ax,
  input  logic               acc_input_ready,
  input  logic               acc_output_valid,
  output logic               acc_output_ready,
  input  logic [2*WIDTH-1:0] acc_res,
  output logic [5:0]         acc_dp_read_addr,
  input  logic               acc_busy
);

  localparam logic [7:0] NUM_WORDS  = 8'd192;
  localparam logic [7:0] LAST_IDX   = 8'd191;
  localparam logic [2:0] LAST_BATCH = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_COLLECT,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [7:0]       r_idx;
  logic [2:0]       r_batch;
  logic             r_busy;
  logic             r_done;
  logic             r_in_valid;
  logic [WIDTH-1:0] r_ax;
  logic [31:0]      r_cycles;
  logic [WIDTH-1:0] r_buf     [0:191];
  logic [WIDTH-1:0] r_results [0:5];

  logic w_idle_like;
  logic w_start_ok;
  logic w_wr_ok;
  logic w_xfer;
  logic w_res_hs;
  logic w_running;
  logic w_unused_res_hi;

  assign w_idle_like     = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_running       = (r_state == ST_STREAM) || (r_state == ST_COLLECT);
  assign w_start_ok      = w_idle_like && start && !acc_busy;
  assign w_wr_ok         = w_idle_like && wr_en && (wr_addr < NUM_WORDS);
  assign w_xfer          = r_in_valid && acc_input_ready;
  assign w_res_hs        = (r_state == ST_COLLECT) && acc_output_valid;
  assign w_unused_res_hi = ^acc_res[2*WIDTH-1:WIDTH];

  // NOTE: the vector buffer is intentionally not reset, so its contents survive a reset.
  always_ff @(posedge clock) begin
    if (w_wr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  // NOTE: every state update uses <= so all branches see the pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_batch    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_in_valid <= 1'b0;
      r_ax       <= '0;
      r_cycles   <= '0;
      for (int i = 0; i < 6; i++) begin
        r_results[i] <= '0;
      end
    end else begin
      if (w_running && (r_cycles != 32'hFFFF_FFFF)) begin
        r_cycles <= r_cycles + 32'd1;
      end

      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_state    <= ST_STREAM;
            r_idx      <= '0;
            r_batch    <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_in_valid <= 1'b1;
            r_ax       <= r_buf[0];
            r_cycles   <= '0;
            for (int i = 0; i < 6; i++) begin
              r_results[i] <= '0;
            end
          end
        end

        ST_STREAM: begin
          // Next word is prefetched on the transfer edge, so acc_ax holds during stalls.
          if (w_xfer) begin
            if (r_idx == LAST_IDX) begin
              r_state    <= ST_COLLECT;
              r_in_valid <= 1'b0;
              r_ax       <= '0;
            end else begin
              r_idx <= r_idx + 8'd1;
              r_ax  <= r_buf[r_idx + 8'd1];
            end
          end
        end

        ST_COLLECT: begin
          if (w_res_hs) begin
            r_results[r_batch] <= acc_res[WIDTH-1:0];
            if (r_batch == LAST_BATCH) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_batch <= r_batch + 3'd1;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      3'd0:    rd_data = r_results[0];
      3'd1:    rd_data = r_results[1];
      3'd2:    rd_data = r_results[2];
      3'd3:    rd_data = r_results[3];
      3'd4:    rd_data = r_results[4];
      3'd5:    rd_data = r_results[5];
      default: rd_data = '0;
    endcase
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign cycle_count      = r_cycles;
  assign acc_input_valid  = r_in_valid;
  assign acc_ax           = r_ax;
  assign acc_output_ready = (r_state == ST_COLLECT) && acc_output_valid;
  assign acc_dp_read_addr = {3'b000, r_batch};

endmodule
